vtage_bank: RTL and testbench

Parametrised VTAGE tagged component bank holding P_NUM_ENTRIES value-prediction entries (valid, tag, value, confidence, usefulness) with P_NUM_PRED independent lookup ports and P_NUM_PRED independent update ports. Lookups return registered hit/value/confidence one cycle later. Updates apply saturating confidence/usefulness rules, value replacement, guarded allocation and periodic usefulness decay. Sits between the VP lookup stage (one instance per tagged table) and the commit-time VP feedback path.

---
 rtl/vtage_pkg.sv | 24 ++
 rtl/vtage.sv | 58 +++++
 rtl/vtage_sat_ctr.sv | 42 ++++
 rtl/vtage_bank.sv | 239 +++++++++++++++++++++++
 tb/tb_vtage_bank.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vtage_pkg.sv
// rtl/vtage_pkg.sv - shared types and constants for the VTAGE tagged bank
//
// Holds the update opcode enum, the usefulness counter geometry and the
// helper that derives the saturation ceiling of a confidence counter from
// its width. The entry record itself depends on bank parameters, so it is
// declared inside vtage_bank.

package vtage_pkg;

    typedef enum logic [1:0] {
        OP_NONE    = 2'd0,
        OP_HIT_OK  = 2'd1,
        OP_HIT_BAD = 2'd2,
        OP_ALLOC   = 2'd3
    } vtage_op_e;

    localparam int                      USEFUL_WIDTH = 2;
    localparam logic [USEFUL_WIDTH-1:0] USEFUL_MAX   = 2'd3;

    function automatic int conf_max(input int conf_width);
        return (1 << conf_width) - 1;
    endfunction

endpackage

// File: rtl/vtage.sv
// rtl/vtage.sv - registered lookup-port result slice for the VTAGE bank
//
// Carries the bank's lookup-port register slice, instantiated by
// vtage_bank once per lookup port.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   hit_i ... conf_ok_i  next-cycle lookup result for one port
//   hit_o ... confident_o registered lookup result

module vtage_rd_slice #(
    parameter int P_VALUE_WIDTH = 64,
    parameter int P_CONF_WIDTH  = 3,
    parameter int P_USEFUL_W    = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     hit_i,
    input  logic [P_VALUE_WIDTH-1:0] value_i,
    input  logic [P_CONF_WIDTH-1:0]  conf_i,
    input  logic [P_USEFUL_W-1:0]    useful_i,
    input  logic                     conf_ok_i,
    output logic                     hit_o,
    output logic [P_VALUE_WIDTH-1:0] value_o,
    output logic [P_CONF_WIDTH-1:0]  conf_o,
    output logic [P_USEFUL_W-1:0]    useful_o,
    output logic                     confident_o
);

    logic                     hit_q;
    logic [P_VALUE_WIDTH-1:0] value_q;
    logic [P_CONF_WIDTH-1:0]  conf_q;
    logic [P_USEFUL_W-1:0]    useful_q;
    logic                     confident_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_q       <= 1'b0;
            value_q     <= '0;
            conf_q      <= '0;
            useful_q    <= '0;
            confident_q <= 1'b0;
        end else begin
            hit_q       <= hit_i;
            value_q     <= value_i;
            conf_q      <= conf_i;
            useful_q    <= useful_i;
            confident_q <= hit_i & conf_ok_i;
        end
    end

    assign hit_o       = hit_q;
    assign value_o     = value_q;
    assign conf_o      = conf_q;
    assign useful_o    = useful_q;
    assign confident_o = confident_q;

endmodule

// File: rtl/vtage_sat_ctr.sv
// rtl/vtage_sat_ctr.sv - combinational saturating counter next-value
//
// Ports:
//   val_i      current counter value
//   inc_i      +1, held at P_MAX
//   dec_i      -1, held at 0
//   clr_i      force 0 (highest priority)
//   load_i     load load_val_i (above inc/dec)
//   load_val_i value for load
//   val_o      next counter value

module vtage_sat_ctr #(
    parameter int                 P_WIDTH = 3,
    parameter logic [P_WIDTH-1:0] P_MAX   = '1
) (
    input  logic [P_WIDTH-1:0] val_i,
    input  logic               inc_i,
    input  logic               dec_i,
    input  logic               clr_i,
    input  logic               load_i,
    input  logic [P_WIDTH-1:0] load_val_i,
    output logic [P_WIDTH-1:0] val_o
);

    always_comb begin
        val_o = val_i;
        if (clr_i) begin
            val_o = '0;
        end else if (load_i) begin
            val_o = load_val_i;
        end else if (inc_i) begin
            if (val_i != P_MAX) begin
                val_o = val_i + P_WIDTH'(1);
            end
        end else if (dec_i) begin
            if (val_i != '0) begin
                val_o = val_i - P_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/vtage_bank.sv
// rtl/vtage_bank.sv - VTAGE tagged value-prediction bank
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   rd_*           P_NUM_PRED lookup ports; results registered, one cycle later,
//                  reflecting the array before the same edge's updates
//   upd_*          P_NUM_PRED update ports (opcode, index, tag, value)
//   upd_drop_o     same-cycle: op lost to a lower-numbered port on the same index
//   alloc_fail_o   same-cycle: OP_ALLOC refused because entry still useful
//   decay_o        registered: usefulness halving applied at this cycle's edge

module vtage_bank
    import vtage_pkg::*;
#(
    parameter int  P_NUM_PRED     = 2,
    parameter int  P_NUM_ENTRIES  = 256,
    parameter int  P_TAG_WIDTH    = 15,
    parameter int  P_VALUE_WIDTH  = 64,
    parameter int  P_CONF_WIDTH   = 3,
    parameter int  P_DECAY_PERIOD = 1024,
    localparam int IW             = $clog2(P_NUM_ENTRIES)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [P_NUM_PRED-1:0]                    rd_en_i,
    input  logic [P_NUM_PRED-1:0][IW-1:0]            rd_idx_i,
    input  logic [P_NUM_PRED-1:0][P_TAG_WIDTH-1:0]   rd_tag_i,
    output logic [P_NUM_PRED-1:0]                    rd_hit_o,
    output logic [P_NUM_PRED-1:0][P_VALUE_WIDTH-1:0] rd_value_o,
    output logic [P_NUM_PRED-1:0][P_CONF_WIDTH-1:0]  rd_conf_o,
    output logic [P_NUM_PRED-1:0][1:0]               rd_useful_o,
    output logic [P_NUM_PRED-1:0]                    rd_confident_o,
    input  logic [P_NUM_PRED-1:0][1:0]               upd_op_i,
    input  logic [P_NUM_PRED-1:0][IW-1:0]            upd_idx_i,
    input  logic [P_NUM_PRED-1:0][P_TAG_WIDTH-1:0]   upd_tag_i,
    input  logic [P_NUM_PRED-1:0][P_VALUE_WIDTH-1:0] upd_value_i,
    output logic [P_NUM_PRED-1:0]                    upd_drop_o,
    output logic [P_NUM_PRED-1:0]                    alloc_fail_o,
    output logic                                     decay_o
);

    localparam int                     CW       = P_CONF_WIDTH;
    localparam logic [CW-1:0]          CONF_MAX = CW'(conf_max(CW));
    // Holds the largest pre-wrap sum (period-1 + all ports accepted).
    localparam int                     DW       = $clog2(P_DECAY_PERIOD + P_NUM_PRED + 1);

    typedef struct packed {
        logic                    valid;
        logic [P_TAG_WIDTH-1:0]  tag;
        logic [P_VALUE_WIDTH-1:0] value;
        logic [CW-1:0]           conf;
        logic [USEFUL_WIDTH-1:0] useful;
    } entry_t;

    entry_t                ent [P_NUM_ENTRIES];
    vtage_op_e             upd_op [P_NUM_PRED];
    logic [P_NUM_PRED-1:0] upd_acc;
    logic [P_NUM_PRED-1:0] upd_drop;
    logic [P_NUM_PRED-1:0] alloc_fail;
    logic [DW-1:0]         n_acc;
    logic [DW-1:0]         dsum;
    logic [DW-1:0]         dcnt_q, dcnt_d;
    logic                  decay_q, decay_d;

    // Conflict resolution: the lowest-numbered port claiming an index wins.
    // Accepted indices are therefore unique, so each entry sees at most one op.
    always_comb begin
        upd_acc    = '0;
        upd_drop   = '0;
        alloc_fail = '0;
        n_acc      = '0;
        for (int p = 0; p < P_NUM_PRED; p++) begin
            upd_op[p] = vtage_op_e'(upd_op_i[p]);
        end
        for (int p = 0; p < P_NUM_PRED; p++) begin
            if (upd_op[p] != OP_NONE) begin
                for (int q = 0; q < p; q++) begin
                    if (upd_op[q] != OP_NONE && upd_idx_i[q] == upd_idx_i[p]) begin
                        upd_drop[p] = 1'b1;
                    end
                end
                upd_acc[p] = ~upd_drop[p];
            end
            if (upd_acc[p]) begin
                n_acc = n_acc + DW'(1);
                if (upd_op[p] == OP_ALLOC && ent[upd_idx_i[p]].valid &&
                    ent[upd_idx_i[p]].useful != '0) begin
                    alloc_fail[p] = 1'b1;
                end
            end
        end
    end

    assign upd_drop_o   = upd_drop;
    assign alloc_fail_o = alloc_fail;

    // Decay counter: the crossing cycle arms decay_q, whose edge then halves usefulness.
    always_comb begin
        dsum    = dcnt_q + n_acc;
        dcnt_d  = dsum;
        decay_d = 1'b0;
        if (dsum >= DW'(P_DECAY_PERIOD)) begin
            dcnt_d  = dsum - DW'(P_DECAY_PERIOD);
            decay_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dcnt_q  <= '0;
            decay_q <= 1'b0;
        end else begin
            dcnt_q  <= dcnt_d;
            decay_q <= decay_d;
        end
    end

    assign decay_o = decay_q;

    for (genvar e = 0; e < P_NUM_ENTRIES; e++) begin : g_ent
        vtage_op_e                op;
        logic [P_TAG_WIDTH-1:0]   w_tag;
        logic [P_VALUE_WIDTH-1:0] w_value;
        logic                     alloc_ok;
        logic [CW-1:0]            conf_upd;
        logic [USEFUL_WIDTH-1:0]  useful_upd;
        entry_t                   ent_q, ent_d;

        always_comb begin
            op      = OP_NONE;
            w_tag   = '0;
            w_value = '0;
            for (int p = 0; p < P_NUM_PRED; p++) begin
                if (upd_acc[p] && upd_idx_i[p] == IW'(e)) begin
                    op      = upd_op[p];
                    w_tag   = upd_tag_i[p];
                    w_value = upd_value_i[p];
                end
            end
        end

        assign alloc_ok = (op == OP_ALLOC) && (!ent_q.valid || ent_q.useful == '0);

        // A mispredict at zero confidence retrains the value; otherwise it only resets confidence.
        vtage_sat_ctr #(
            .P_WIDTH (CW),
            .P_MAX   (CONF_MAX)
        ) u_conf (
            .val_i      (ent_q.conf),
            .inc_i      (op == OP_HIT_OK),
            .dec_i      (1'b0),
            .clr_i      (alloc_ok || (op == OP_HIT_BAD && ent_q.conf != '0)),
            .load_i     (1'b0),
            .load_val_i ('0),
            .val_o      (conf_upd)
        );

        // A refused allocation ages the occupant so a later attempt can succeed.
        vtage_sat_ctr #(
            .P_WIDTH (USEFUL_WIDTH),
            .P_MAX   (USEFUL_MAX)
        ) u_useful (
            .val_i      (ent_q.useful),
            .inc_i      (op == OP_HIT_OK),
            .dec_i      (op == OP_HIT_BAD || (op == OP_ALLOC && !alloc_ok)),
            .clr_i      (alloc_ok),
            .load_i     (1'b0),
            .load_val_i ('0),
            .val_o      (useful_upd)
        );

        always_comb begin
            ent_d      = ent_q;
            ent_d.conf = conf_upd;
            ent_d.useful = decay_q ? (useful_upd >> 1) : useful_upd;
            if (alloc_ok) begin
                ent_d.valid = 1'b1;
                ent_d.tag   = w_tag;
                ent_d.value = w_value;
            end
            if (op == OP_HIT_BAD && ent_q.conf == '0) begin
                ent_d.value = w_value;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                ent_q <= '0;
            end else begin
                ent_q <= ent_d;
            end
        end

        assign ent[e] = ent_q;
    end

    for (genvar p = 0; p < P_NUM_PRED; p++) begin : g_rd
        logic                     hit_d;
        logic [P_VALUE_WIDTH-1:0] value_d;
        logic [CW-1:0]            conf_d;
        logic [USEFUL_WIDTH-1:0]  useful_d;
        logic                     conf_ok_d;

        always_comb begin
            hit_d     = 1'b0;
            value_d   = '0;
            conf_d    = '0;
            useful_d  = '0;
            conf_ok_d = 1'b0;
            if (rd_en_i[p]) begin
                hit_d     = ent[rd_idx_i[p]].valid && (ent[rd_idx_i[p]].tag == rd_tag_i[p]);
                value_d   = ent[rd_idx_i[p]].value;
                conf_d    = ent[rd_idx_i[p]].conf;
                useful_d  = ent[rd_idx_i[p]].useful;
                conf_ok_d = (ent[rd_idx_i[p]].conf == CONF_MAX);
            end
        end

        vtage_rd_slice #(
            .P_VALUE_WIDTH (P_VALUE_WIDTH),
            .P_CONF_WIDTH  (CW),
            .P_USEFUL_W    (USEFUL_WIDTH)
        ) u_rd (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .hit_i       (hit_d),
            .value_i     (value_d),
            .conf_i      (conf_d),
            .useful_i    (useful_d),
            .conf_ok_i   (conf_ok_d),
            .hit_o       (rd_hit_o[p]),
            .value_o     (rd_value_o[p]),
            .conf_o      (rd_conf_o[p]),
            .useful_o    (rd_useful_o[p]),
            .confident_o (rd_confident_o[p])
        );
    end

endmodule

// File: tb/tb_vtage_bank.sv
// tb/tb_vtage_bank.sv - scoreboard bench for vtage_bank

module tb_vtage_bank;
    import vtage_pkg::*;

    localparam int NP   = 2;
    localparam int NE   = 16;
    localparam int TW   = 15;
    localparam int VW   = 64;
    localparam int CWD  = 3;
    localparam int DP   = 8;
    localparam int IW   = 4;
    localparam int CMAX = 7;

    logic                     clk, rst;
    logic [NP-1:0]            rd_en;
    logic [NP-1:0][IW-1:0]    rd_idx;
    logic [NP-1:0][TW-1:0]    rd_tag;
    logic [NP-1:0]            rd_hit;
    logic [NP-1:0][VW-1:0]    rd_value;
    logic [NP-1:0][CWD-1:0]   rd_conf;
    logic [NP-1:0][1:0]       rd_useful;
    logic [NP-1:0]            rd_confident;
    logic [NP-1:0][1:0]       upd_op;
    logic [NP-1:0][IW-1:0]    upd_idx;
    logic [NP-1:0][TW-1:0]    upd_tag;
    logic [NP-1:0][VW-1:0]    upd_value;
    logic [NP-1:0]            upd_drop;
    logic [NP-1:0]            alloc_fail;
    logic                     decay;

    vtage_bank #(
        .P_NUM_PRED     (NP),
        .P_NUM_ENTRIES  (NE),
        .P_TAG_WIDTH    (TW),
        .P_VALUE_WIDTH  (VW),
        .P_CONF_WIDTH   (CWD),
        .P_DECAY_PERIOD (DP)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .rd_en_i        (rd_en),
        .rd_idx_i       (rd_idx),
        .rd_tag_i       (rd_tag),
        .rd_hit_o       (rd_hit),
        .rd_value_o     (rd_value),
        .rd_conf_o      (rd_conf),
        .rd_useful_o    (rd_useful),
        .rd_confident_o (rd_confident),
        .upd_op_i       (upd_op),
        .upd_idx_i      (upd_idx),
        .upd_tag_i      (upd_tag),
        .upd_value_i    (upd_value),
        .upd_drop_o     (upd_drop),
        .alloc_fail_o   (alloc_fail),
        .decay_o        (decay)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NP-1:0] drop;
        logic [NP-1:0] afail;
        bit            clear;
    } comb_exp_t;

    typedef struct {
        logic [NP-1:0]          hit;
        logic [NP-1:0][VW-1:0]  value;
        logic [NP-1:0][CWD-1:0] conf;
        logic [NP-1:0][1:0]     useful;
        logic [NP-1:0]          confident;
        logic                   decay;
    } reg_exp_t;

    comb_exp_t cq[$];
    reg_exp_t  rq[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain integers, saturation by min/max.
    bit            m_valid  [NE];
    logic [TW-1:0] m_tag    [NE];
    logic [VW-1:0] m_value  [NE];
    int            m_conf   [NE];
    int            m_useful [NE];
    int            m_cnt;
    bit            m_pend;

    logic [TW-1:0] tag_pool [4];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int e = 0; e < NE; e++) begin
            m_valid[e]  = 1'b0;
            m_tag[e]    = '0;
            m_value[e]  = '0;
            m_conf[e]   = 0;
            m_useful[e] = 0;
        end
        m_cnt  = 0;
        m_pend = 1'b0;
    endfunction

    task automatic idle();
        rd_en     = '0;
        rd_idx    = '0;
        rd_tag    = '0;
        upd_op    = '0;
        upd_idx   = '0;
        upd_tag   = '0;
        upd_value = '0;
    endtask

    task automatic look(input int p, input int idx, input logic [TW-1:0] tag);
        rd_en[p]  = 1'b1;
        rd_idx[p] = IW'(idx);
        rd_tag[p] = tag;
    endtask

    task automatic upd(input int p, input vtage_op_e op, input int idx,
                       input logic [TW-1:0] tag, input logic [VW-1:0] val);
        upd_op[p]    = op;
        upd_idx[p]   = IW'(idx);
        upd_tag[p]   = tag;
        upd_value[p] = val;
    endtask

    // Inputs are already driven; predict this cycle's outcome, queue it, advance one clock.
    task automatic step(input bit do_rst);
        comb_exp_t c;
        reg_exp_t  r;
        bit        acc [NP];
        bit        d;
        int        i, nacc;
        c.drop = '0; c.afail = '0; c.clear = do_rst;
        r.hit = '0; r.value = '0; r.conf = '0; r.useful = '0; r.confident = '0; r.decay = 1'b0;
        if (do_rst) begin
            model_reset();
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (rd_en[p]) begin
                    i = int'(rd_idx[p]);
                    r.hit[p]       = m_valid[i] && (m_tag[i] == rd_tag[p]);
                    r.value[p]     = m_value[i];
                    r.conf[p]      = CWD'(m_conf[i]);
                    r.useful[p]    = 2'(m_useful[i]);
                    r.confident[p] = r.hit[p] && (m_conf[i] == CMAX);
                end
            end
            nacc = 0;
            for (int p = 0; p < NP; p++) begin
                acc[p] = 1'b0;
                if (upd_op[p] != OP_NONE) begin
                    d = 1'b0;
                    for (int q = 0; q < p; q++) begin
                        if (upd_op[q] != OP_NONE && upd_idx[q] == upd_idx[p]) d = 1'b1;
                    end
                    c.drop[p] = d;
                    acc[p]    = !d;
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (acc[p]) begin
                    nacc++;
                    i = int'(upd_idx[p]);
                    case (upd_op[p])
                        OP_HIT_OK: begin
                            m_conf[i]   = (m_conf[i] + 1 > CMAX) ? CMAX : m_conf[i] + 1;
                            m_useful[i] = (m_useful[i] + 1 > 3) ? 3 : m_useful[i] + 1;
                        end
                        OP_HIT_BAD: begin
                            if (m_conf[i] == 0) m_value[i] = upd_value[p];
                            else                m_conf[i]  = 0;
                            m_useful[i] = (m_useful[i] > 0) ? m_useful[i] - 1 : 0;
                        end
                        default: begin
                            if (!m_valid[i] || m_useful[i] == 0) begin
                                m_valid[i]  = 1'b1;
                                m_tag[i]    = upd_tag[p];
                                m_value[i]  = upd_value[p];
                                m_conf[i]   = 0;
                                m_useful[i] = 0;
                            end else begin
                                m_useful[i] = m_useful[i] - 1;
                                c.afail[p]  = 1'b1;
                            end
                        end
                    endcase
                end
            end
            if (m_pend) begin
                for (int e = 0; e < NE; e++) m_useful[e] = m_useful[e] / 2;
            end
            m_cnt = m_cnt + nacc;
            if (m_cnt >= DP) begin
                m_cnt  = m_cnt - DP;
                m_pend = 1'b1;
            end else begin
                m_pend = 1'b0;
            end
            r.decay = m_pend;
        end
        cq.push_back(c);
        rq.push_back(r);
        @(negedge clk);
    endtask

    // Same-cycle flags, sampled while the cycle's inputs are held.
    initial begin
        comb_exp_t c;
        forever begin
            @(negedge clk);
            #2;
            if (cq.size() > 0) begin
                c = cq.pop_front();
                check("upd_drop", 64'(upd_drop), 64'(c.drop));
                check("alloc_fail", 64'(alloc_fail), 64'(c.afail));
                if (c.clear) begin
                    check("reset_clears_outputs",
                          {58'd0, |rd_hit, |rd_value, |rd_conf, |rd_useful, |rd_confident, decay}, 64'd0);
                end
            end
        end
    end

    // Registered lookup results and decay pulse, sampled after the edge.
    initial begin
        reg_exp_t r;
        forever begin
            @(posedge clk);
            #1;
            if (rq.size() > 0) begin
                r = rq.pop_front();
                for (int p = 0; p < NP; p++) begin
                    check($sformatf("rd_hit[%0d]", p), 64'(rd_hit[p]), 64'(r.hit[p]));
                    check($sformatf("rd_value[%0d]", p), rd_value[p], r.value[p]);
                    check($sformatf("rd_conf[%0d]", p), 64'(rd_conf[p]), 64'(r.conf[p]));
                    check($sformatf("rd_useful[%0d]", p), 64'(rd_useful[p]), 64'(r.useful[p]));
                    check($sformatf("rd_confident[%0d]", p), 64'(rd_confident[p]), 64'(r.confident[p]));
                end
                check("decay_o", 64'(decay), 64'(r.decay));
            end
        end
    end

    initial begin
        int k;
        tag_pool[0] = 15'h12;
        tag_pool[1] = 15'h34;
        tag_pool[2] = 15'h7ABC;
        tag_pool[3] = 15'h0001;
        model_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        step(1'b1);
        rst = 1'b0;

        // empty table lookup
        idle(); look(0, 5, 15'h12); step(1'b0);
        // allocate, then train confidence to saturation and beyond
        idle(); upd(0, OP_ALLOC, 5, 15'h12, 64'hDEAD); step(1'b0);
        for (int n = 0; n < 8; n++) begin
            idle(); look(0, 5, 15'h12); upd(0, OP_HIT_OK, 5, 15'h12, 64'h0); step(1'b0);
        end
        idle(); look(0, 5, 15'h12); step(1'b0);
        // mispredicts: first clears confidence, second retrains the value
        for (int n = 0; n < 2; n++) begin
            idle(); look(0, 5, 15'h12); upd(0, OP_HIT_BAD, 5, 15'h12, 64'hBEEF); step(1'b0);
        end
        idle(); look(0, 5, 15'h12); step(1'b0);
        // rebuild usefulness then contend with another tag
        for (int n = 0; n < 2; n++) begin
            idle(); upd(0, OP_HIT_OK, 5, 15'h12, 64'h0); step(1'b0);
        end
        for (int n = 0; n < 4; n++) begin
            idle(); look(0, 5, 15'h12); look(1, 5, 15'h34);
            upd(0, OP_ALLOC, 5, 15'h34, 64'h5555); step(1'b0);
        end
        // same-index conflict with a same-cycle lookup of the pre-update state
        idle(); upd(0, OP_ALLOC, 9, 15'h7ABC, 64'h99); step(1'b0);
        idle(); look(0, 9, 15'h7ABC);
        upd(0, OP_HIT_OK, 9, 15'h0, 64'h0); upd(1, OP_HIT_OK, 9, 15'h0, 64'h0); step(1'b0);
        idle(); look(0, 9, 15'h7ABC); look(1, 5, 15'h34); step(1'b0);
        // usefulness build-up on idx 3, then let decay fire
        idle(); upd(0, OP_ALLOC, 3, 15'h1, 64'h3); step(1'b0);
        for (int n = 0; n < 6; n++) begin
            idle(); look(0, 3, 15'h1); upd(0, OP_HIT_OK, 3, 15'h1, 64'h0);
            upd(1, OP_HIT_OK, 4, 15'h0, 64'h0); step(1'b0);
        end
        for (int n = 0; n < 3; n++) begin
            idle(); look(0, 3, 15'h1); look(1, 4, 15'h0); step(1'b0);
        end
        // arm a decay, then reset before it lands
        k = 0;
        idle();
        while (!m_pend && k < 20) begin
            idle(); upd(0, OP_HIT_OK, 3, 15'h0, 64'h0); upd(1, OP_HIT_OK, 4, 15'h0, 64'h0);
            step(1'b0);
            k++;
        end
        check("decay_armed_within_budget", 64'(m_pend), 64'd1);
        idle(); rst = 1'b1; step(1'b1); rst = 1'b0;
        idle(); look(0, 3, 15'h1); look(1, 5, 15'h12); step(1'b0);
        idle(); look(0, 3, 15'h1); step(1'b0);

        // randomized traffic with occasional reset
        for (int n = 0; n < 1500; n++) begin
            for (int p = 0; p < NP; p++) begin
                rd_en[p]     = ($urandom_range(0, 3) != 0);
                rd_idx[p]    = IW'($urandom_range(0, NE - 1));
                rd_tag[p]    = tag_pool[$urandom_range(0, 3)];
                upd_op[p]    = 2'($urandom_range(0, 3));
                upd_idx[p]   = IW'($urandom_range(0, 7));
                upd_tag[p]   = tag_pool[$urandom_range(0, 3)];
                upd_value[p] = {$urandom, $urandom};
            end
            if ($urandom_range(0, 299) == 0) begin
                idle(); rst = 1'b1; step(1'b1); rst = 1'b0;
            end else begin
                step(1'b0);
            end
        end

        idle();
        @(negedge clk);
        #5;
        check("comb_queue_drained", 64'(cq.size()), 64'd0);
        check("reg_queue_drained", 64'(rq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
